// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Bus-side signal bundle of the UART receiver: FIFO pop,
//                overrun clear, head word with its error flags and fill level.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
);
    logic                       read_en;
    logic                       clear_overrun;
    logic                       data_ready;
    logic [DATA_BITS-1:0]       data_out;
    logic                       parity_error;
    logic                       framing_error;
    logic                       overrun;
    logic [FIFO_DEPTH_LOG2:0]   fifo_count;

    // CPU / device side
    modport master (
        output read_en, clear_overrun,
        input  data_ready, data_out, parity_error, framing_error, overrun, fifo_count
    );

    // Receiver side
    modport slave (
        input  read_en, clear_overrun,
        output data_ready, data_out, parity_error, framing_error, overrun, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Oversampling UART receiver with runtime frame format
//                (parity none/even/odd, one or two stop bits) feeding a
//                first-word-fall-through FIFO of {data, perr, ferr} words.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] clock_divider,
    input  logic [1:0]  parity_mode,
    input  logic        two_stop,
    input  logic        rx,
    uart_rx_fifo_if.slave bus
);

    localparam int c_DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int c_WORD_W = DATA_BITS + 2;
    localparam int c_IDX_W  = 4;
    localparam logic [c_IDX_W-1:0]         c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   c_FULL     = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP1  = 3'd4;
    localparam logic [2:0] c_STOP2  = 3'd5;
    localparam logic [2:0] c_BREAK  = 3'd6;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     w_rx_s;
    logic [2:0]               r_state;
    logic [2:0]               w_state_next;
    logic [15:0]              r_div;
    logic [15:0]              r_cnt;
    logic [15:0]              w_div_in;
    logic [1:0]               r_pmode;
    logic                     r_two_stop;
    logic [DATA_BITS-1:0]     r_shift;
    logic [c_IDX_W-1:0]       r_idx;
    logic                     r_perr;
    logic                     r_push;
    logic [c_WORD_W-1:0]      r_push_word;
    logic                     w_sample;
    logic                     w_par_en;
    logic                     w_par_exp;
    logic                     w_start;
    logic                     w_shift;
    logic                     w_perr_set;
    logic                     w_push_set;

    assign w_rx_s    = r_sync[SYNC_STAGES-1];
    assign w_div_in  = (clock_divider < 16'd4) ? 16'd4 : clock_divider;
    assign w_sample  = (r_cnt == r_div);
    assign w_par_en  = (r_pmode == 2'b01) || (r_pmode == 2'b10);
    assign w_par_exp = (^r_shift) ^ (r_pmode == 2'b10);

    // Bring the asynchronous rx line into the clock domain; idle level is 1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    // Frame state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-sample actions; every decision waits for the sample point
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_perr_set   = 1'b0;
        w_push_set   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_rx_s) begin
                    w_start      = 1'b1;
                    w_state_next = c_START;
                end
            end
            c_START: begin
                if (w_sample) begin
                    w_state_next = w_rx_s ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_sample) begin
                    w_shift = 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_next = w_par_en ? c_PARITY : c_STOP1;
                    end
                end
            end
            c_PARITY: begin
                if (w_sample) begin
                    w_perr_set   = (w_rx_s != w_par_exp);
                    w_state_next = c_STOP1;
                end
            end
            c_STOP1: begin
                if (w_sample) begin
                    if (r_two_stop && w_rx_s) begin
                        w_state_next = c_STOP2;
                    end else begin
                        w_push_set   = 1'b1;
                        w_state_next = w_rx_s ? c_IDLE : c_BREAK;
                    end
                end
            end
            c_STOP2: begin
                if (w_sample) begin
                    w_push_set   = 1'b1;
                    w_state_next = w_rx_s ? c_IDLE : c_BREAK;
                end
            end
            c_BREAK: begin
                if (w_rx_s) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Bit timing, configuration latch, data shifter and the registered push request.
    // The counter is preloaded to half a bit so samples land mid-bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= 16'd4;
            r_cnt       <= 16'd1;
            r_pmode     <= 2'b00;
            r_two_stop  <= 1'b0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_perr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_push <= w_push_set;
            if (w_push_set) begin
                // The final stop sample alone decides ferr: an earlier bad stop
                // would already have caused the push.
                r_push_word <= {r_shift, r_perr, ~w_rx_s};
            end
            if (w_start) begin
                r_div      <= w_div_in;
                r_pmode    <= parity_mode;
                r_two_stop <= two_stop;
                r_cnt      <= {1'b0, w_div_in[15:1]} + 16'd1;
                r_perr     <= 1'b0;
                r_idx      <= '0;
            end else if ((r_state != c_IDLE) && (r_state != c_BREAK)) begin
                r_cnt <= w_sample ? 16'd1 : (r_cnt + 16'd1);
            end
            if (w_shift) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_idx   <= r_idx + c_IDX_W'(1);
            end
            if (w_perr_set) begin
                r_perr <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0]          r_mem [c_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]     r_count;
    logic [c_WORD_W-1:0]          r_hold;
    logic                         r_overrun;
    logic [c_WORD_W-1:0]          w_head;
    logic [c_WORD_W-1:0]          w_out;
    logic                         w_empty;
    logic                         w_full;
    logic                         w_pop;
    logic                         w_wr;
    logic                         w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = bus.read_en && !w_empty;
    // A push into a full FIFO still lands if a pop frees the slot this cycle
    assign w_wr    = r_push && (!w_full || w_pop);
    assign w_drop  = r_push && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];
    // When empty, present the last head seen so outputs hold steady
    assign w_out   = w_empty ? r_hold : w_head;

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_word;
        end
    end

    // Pointers, fill level, hold register and sticky overrun (set beats clear)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_hold    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (FIFO_DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (!w_empty) begin
                r_hold <= w_head;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.data_ready    = !w_empty;
    assign bus.data_out      = w_out[c_WORD_W-1:2];
    assign bus.parity_error  = w_out[1];
    assign bus.framing_error = w_out[0];
    assign bus.overrun       = r_overrun;
    assign bus.fifo_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo: directed frame table,
//                break / overflow / glitch / back-to-back / reset sequences,
//                and randomized frames against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] clock_divider = 16'd16;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic        rx = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH_LOG2(4)) bus ();

    uart_rx_fifo #(
        .DATA_BITS(8),
        .FIFO_DEPTH_LOG2(4),
        .SYNC_STAGES(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .clock_divider(clock_divider),
        .parity_mode(parity_mode),
        .two_stop(two_stop),
        .rx(rx),
        .bus(bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] pm;
        logic       two;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic [7:0] e_data;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    word_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive rx at the current negedge and keep it for a number of cycles
    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input int div, input logic [1:0] pm,
                              input logic two, input logic pbit, input logic s1,
                              input logic s2, input int last_len);
        int de;
        de = (div < 4) ? 4 : div;
        clock_divider = 16'(div);
        parity_mode   = pm;
        two_stop      = two;
        hold(1'b0, de);
        for (int i = 0; i < 8; i++) hold(d[i], de);
        if (pm == 2'b01 || pm == 2'b10) hold(pbit, de);
        if (two) begin
            hold(s1, de);
            hold(s2, last_len);
        end else begin
            hold(s1, last_len);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] d, input logic pe, input logic fe);
        check({name, " ready"}, bus.data_ready, 1'b1);
        check({name, " data"},  bus.data_out, d);
        check({name, " perr"},  bus.parity_error, pe);
        check({name, " ferr"},  bus.framing_error, fe);
        bus.read_en = 1'b1;
        @(negedge clock);
        bus.read_en = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[3] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[4] = '{8'h03, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h5A, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};

        bus.read_en       = 1'b0;
        bus.clear_overrun = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check("rst data_ready", bus.data_ready, 1'b0);
        check("rst data_out",   bus.data_out, 8'h00);
        check("rst perr",       bus.parity_error, 1'b0);
        check("rst ferr",       bus.framing_error, 1'b0);
        check("rst overrun",    bus.overrun, 1'b0);
        check("rst count",      bus.fifo_count, 5'd0);
        reset_n = 1'b1;
        hold(1'b1, 8);

        // ---------------- directed frame table ----------------
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].data, 16, vecs[i].pm, vecs[i].two, vecs[i].pbit,
                       vecs[i].s1, vecs[i].s2, 16);
            hold(1'b1, 32);
            check($sformatf("vec%0d count", i), bus.fifo_count, 5'd1);
            pop_check($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr);
            check($sformatf("vec%0d empty", i), bus.data_ready, 1'b0);
            check($sformatf("vec%0d hold", i), bus.data_out, vecs[i].e_data);
        end

        // ---------------- stop bit low, then line held low ----------------
        send_frame(8'h55, 16, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        hold(1'b0, 40 * 16);
        check("break count", bus.fifo_count, 5'd1);
        hold(1'b1, 16);
        send_frame(8'h12, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        hold(1'b1, 32);
        check("break+1 count", bus.fifo_count, 5'd2);
        pop_check("break word", 8'h55, 1'b0, 1'b1);
        pop_check("after break", 8'h12, 1'b0, 1'b0);

        // line low from idle: exactly one all-zero word with ferr
        hold(1'b0, 40 * 16);
        hold(1'b1, 16);
        check("low line count", bus.fifo_count, 5'd1);
        pop_check("low line", 8'h00, 1'b0, 1'b1);

        // ---------------- overflow ----------------
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        end
        hold(1'b1, 32);
        check("ovf count",   bus.fifo_count, 5'd16);
        check("ovf overrun", bus.overrun, 1'b1);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("ovf head%0d", i), 8'(i), 1'b0, 1'b0);
        end
        check("ovf drained",        bus.data_ready, 1'b0);
        check("ovf overrun sticky", bus.overrun, 1'b1);
        bus.clear_overrun = 1'b1;
        @(negedge clock);
        bus.clear_overrun = 1'b0;
        check("ovf cleared", bus.overrun, 1'b0);

        // ---------------- glitch and back-to-back ----------------
        hold(1'b0, 3);
        hold(1'b1, 48);
        check("glitch count", bus.fifo_count, 5'd0);
        check("glitch ready", bus.data_ready, 1'b0);
        // stop bit lasts only until one cycle past its sample point
        send_frame(8'h3C, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 9);
        send_frame(8'hC3, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        hold(1'b1, 32);
        check("b2b count", bus.fifo_count, 5'd2);
        pop_check("b2b first", 8'h3C, 1'b0, 1'b0);
        pop_check("b2b second", 8'hC3, 1'b0, 1'b0);

        // ---------------- reset in the middle of a frame ----------------
        send_frame(8'h11, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        hold(1'b1, 32);
        check("mid-rst pre count", bus.fifo_count, 5'd1);
        hold(1'b0, 16);
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 8);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clock);
        check("mid-rst count", bus.fifo_count, 5'd0);
        check("mid-rst ready", bus.data_ready, 1'b0);
        reset_n = 1'b1;
        hold(1'b1, 48);
        check("post-rst no push", bus.fifo_count, 5'd0);
        send_frame(8'h33, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        hold(1'b1, 32);
        pop_check("post-rst", 8'h33, 1'b0, 1'b0);

        // ---------------- randomized frames vs. reference model ----------------
        for (int b = 0; b < 15; b++) begin
            int nb;
            int de;
            nb = $urandom_range(1, 3);
            de = 4;
            for (int f = 0; f < nb; f++) begin
                logic [7:0] d;
                logic [1:0] pm;
                logic       two, pbit, s1, s2;
                int         div;
                word_t      w;
                div  = $urandom_range(0, 20);
                d    = 8'($urandom);
                pm   = 2'($urandom_range(0, 3));
                two  = 1'($urandom_range(0, 1));
                pbit = 1'($urandom_range(0, 1));
                s1   = ($urandom_range(0, 7) != 0);
                s2   = ($urandom_range(0, 7) != 0);
                de   = (div < 4) ? 4 : div;
                send_frame(d, div, pm, two, pbit, s1, s2, de);
                hold(1'b1, de);
                w.d  = d;
                // even mode: data+parity carry an even number of ones; odd mode: odd
                w.pe = (pm == 2'b01 || pm == 2'b10) &&
                       ((($countones(d) + int'(pbit)) % 2) != ((pm == 2'b10) ? 1 : 0));
                w.fe = !s1 || (two && !s2);
                q.push_back(w);
            end
            hold(1'b1, 2 * de + 8);
            check($sformatf("rnd%0d count", b), bus.fifo_count, 32'(q.size()));
            while (q.size() > 0) begin
                word_t e;
                e = q.pop_front();
                pop_check($sformatf("rnd%0d", b), e.d, e.pe, e.fe);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
